// File: rtl/data_mem_pipe.sv
// Byte-addressable synchronous data memory with a valid/ready request port,
// a fixed-latency in-order response pipeline and address-range error flagging.
module data_mem_pipe #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          RAM_DEPTH    = 1024,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR    = 32'h0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [31:0]             req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_mask,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int LB    = $clog2(NB);
  localparam int AW    = $clog2(RAM_DEPTH);
  localparam int WORDS = RAM_DEPTH / NB;
  localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int LAST  = READ_LATENCY - 1;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  logic [READ_LATENCY-1:0] vld_p;
  logic [READ_LATENCY-1:0] err_p;
  logic [DATA_WIDTH-1:0]   rdata_p [READ_LATENCY];

  logic          advance;
  logic          accept;
  logic          in_range;
  logic [31:0]   off;
  logic [IW-1:0] idx;

  // The whole pipeline stalls as one unit while the output stage is held.
  assign advance   = !vld_p[LAST] || resp_ready;
  assign req_ready = advance;
  assign accept    = req_valid && advance;

  // BASE_ADDR is RAM_DEPTH aligned, so the range test is a plain upper-bit match.
  assign in_range = (req_addr[31:AW] == BASE_ADDR[31:AW]);
  assign off      = req_addr - BASE_ADDR;
  assign idx      = IW'(off >> LB);

  always_ff @(posedge clk) begin
    if (accept && req_we && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (req_mask[b]) mem[idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
      end
    end
  end

  // Stage S1 captures the RAM read at acceptance; later stages only delay it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      err_p <= '0;
    end else if (advance) begin
      vld_p[0] <= req_valid;
      err_p[0] <= req_valid && !in_range;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
        err_p[i] <= err_p[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      rdata_p[0] <= (req_valid && !req_we && in_range) ? mem[idx] : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rdata_p[i] <= rdata_p[i-1];
      end
    end
  end

  // Output stage
  assign resp_valid = vld_p[LAST];
  assign resp_err   = vld_p[LAST] && err_p[LAST];
  assign resp_rdata = vld_p[LAST] ? rdata_p[LAST] : '0;

endmodule

// File: tb/tb_data_mem_pipe.sv
// Self-checking bench for data_mem_pipe: directed scenarios plus randomized
// traffic, scored against a word-array memory model and an in-order response queue.
module tb_data_mem_pipe;

  localparam int          DW   = 32;
  localparam int          DEP  = 1024;
  localparam int          LAT  = 3;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [3:0]    req_mask = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;

  data_mem_pipe #(
    .DATA_WIDTH(DW), .RAM_DEPTH(DEP), .READ_LATENCY(LAT), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_resp  = 0;

  logic [31:0] model_mem [DEP/4];
  logic [31:0] exp_d [$];
  bit          exp_e [$];
  int          resp_cyc [$];
  logic [31:0] last_rdata;
  bit          last_err;
  bit          held_v = 1'b0;
  logic [31:0] held_d;
  bit          held_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference behaviour of one accepted request.
  task automatic model_accept(input bit we, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] m);
    logic [31:0] o;
    int          w;
    o = a - BASE;
    w = int'(o[9:2]);
    if (a < BASE || a >= BASE + DEP) begin
      exp_d.push_back(32'h0); exp_e.push_back(1'b1);
    end else if (we) begin
      for (int b = 0; b < 4; b++)
        if (m[b]) model_mem[w][b*8 +: 8] = d[b*8 +: 8];
      exp_d.push_back(32'h0); exp_e.push_back(1'b0);
    end else begin
      exp_d.push_back(model_mem[w]); exp_e.push_back(1'b0);
    end
  endtask

  // One clock cycle: drive after the falling edge, observe, score the handshakes.
  task automatic cycle(input bit v, input bit we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input bit rr, output bit acc);
    @(negedge clk);
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_mask = m; resp_ready = rr;
    #1;
    if (held_v) begin
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, held_d);
      check("hold_err", 32'(resp_err), 32'(held_e));
    end
    held_v = resp_valid && !rr;
    held_d = resp_rdata;
    held_e = resp_err;
    if (resp_valid && rr) begin
      check("resp_expected", 32'(exp_d.size() != 0), 32'd1);
      if (exp_d.size() != 0) begin
        last_rdata = exp_d.pop_front();
        last_err   = exp_e.pop_front();
        check("resp_rdata", resp_rdata, last_rdata);
        check("resp_err", 32'(resp_err), 32'(last_err));
        resp_cyc.push_back(cyc);
        n_resp++;
      end
    end
    acc = v && req_ready;
    if (acc) model_accept(we, a, d, m);
    cyc++;
  endtask

  task automatic req(input bit we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    bit acc;
    int n = 0;
    do begin
      cycle(1'b1, we, a, d, m, 1'b1, acc);
      n++;
    end while (!acc && n < 20);
    check("req_accept", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    while (exp_d.size() != 0 && n < 50) begin
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, acc);
      n++;
    end
    check("drain_empty", 32'(exp_d.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          acc;
    int          a0;
    int          k;
    int          base_resp;
    bit          pend;
    bit          pv, pwe, prr;
    logic [31:0] pa, pd;
    logic [3:0]  pm;

    for (int i = 0; i < DEP/4; i++) model_mem[i] = 32'h0;

    // Reset state
    #2;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);

    // Bring RAM to a known all-zero state through the port
    for (int i = 0; i < DEP/4; i++) req(1'b1, BASE + 32'(i*4), 32'h0, 4'hF);
    drain();

    // Byte-masked stores merge into one word
    req(1'b1, BASE + 32'h10, 32'hAABBCCDD, 4'b1111);
    req(1'b1, BASE + 32'h10, 32'h00000011, 4'b0001);
    req(1'b0, BASE + 32'h10, 32'h0, 4'h0);
    drain();
    check("byte_merge", last_rdata, 32'hAABBCC11);

    // Zero mask store leaves memory unchanged
    req(1'b1, BASE + 32'h10, 32'h12345678, 4'b0000);
    req(1'b0, BASE + 32'h10, 32'h0, 4'h0);
    drain();
    check("mask_zero", last_rdata, 32'hAABBCC11);

    // Read-after-write on consecutive accepts
    req(1'b1, BASE + 32'h20, 32'hDEADBEEF, 4'hF);
    req(1'b0, BASE + 32'h20, 32'h0, 4'h0);
    drain();
    check("raw_hazard", last_rdata, 32'hDEADBEEF);

    // Reset with three loads in flight
    for (int i = 0; i < 3; i++) req(1'b0, BASE + 32'(i*4), 32'h0, 4'h0);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    exp_d.delete(); exp_e.delete();
    held_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, acc);
    check("postrst_req_ready", 32'(req_ready), 32'd1);
    req(1'b0, BASE + 32'h10, 32'h0, 4'h0);
    drain();
    check("store_survives_rst", last_rdata, 32'hAABBCC11);

    // Back-to-back loads: latency and one response per cycle
    for (int i = 0; i < 8; i++) req(1'b1, BASE + 32'h100 + 32'(i*4), 32'hC0DE0000 + 32'(i), 4'hF);
    drain();
    resp_cyc.delete();
    a0 = cyc;
    for (int i = 0; i < 8; i++) req(1'b0, BASE + 32'h100 + 32'(i*4), 32'h0, 4'h0);
    drain();
    check("b2b_count", 32'(resp_cyc.size()), 32'd8);
    if (resp_cyc.size() == 8) begin
      check("b2b_latency", 32'(resp_cyc[0] - a0), 32'(LAT));
      for (int i = 1; i < 8; i++) check("b2b_consecutive", 32'(resp_cyc[i] - resp_cyc[i-1]), 32'd1);
    end
    check("b2b_last_data", last_rdata, 32'hC0DE0007);

    // Back-pressure: consumer stalls 5 cycles while 6 loads stream in
    k = 0;
    base_resp = n_resp;
    for (int c = 0; c < 5; c++) begin
      cycle(1'b1, 1'b0, BASE + 32'h100 + 32'(k*4), 32'h0, 4'h0, 1'b0, acc);
      if (acc) k++;
    end
    check("bp_accepted_while_stalled", 32'(k), 32'(LAT));
    check("bp_req_ready_low", 32'(req_ready), 32'd0);
    for (int c = 0; c < 30 && k < 6; c++) begin
      cycle(1'b1, 1'b0, BASE + 32'h100 + 32'(k*4), 32'h0, 4'h0, 1'b1, acc);
      if (acc) k++;
    end
    drain();
    check("bp_all_delivered", 32'(n_resp - base_resp), 32'd6);
    check("bp_last_data", last_rdata, 32'hC0DE0005);

    // Range boundaries
    req(1'b1, BASE + DEP - 4, 32'h5A5A1234, 4'hF);
    req(1'b0, BASE + DEP - 4, 32'h0, 4'h0);
    drain();
    check("top_word", last_rdata, 32'h5A5A1234);
    req(1'b1, BASE + DEP, 32'hFFFFFFFF, 4'hF);
    req(1'b0, BASE + DEP, 32'h0, 4'h0);
    drain();
    check("above_range_err", 32'(last_err), 32'd1);
    check("above_range_rdata", last_rdata, 32'h0);
    req(1'b0, BASE - 4, 32'h0, 4'h0);
    drain();
    check("below_range_err", 32'(last_err), 32'd1);
    req(1'b0, BASE, 32'h0, 4'h0);
    drain();
    check("no_wrap_word0", last_rdata, 32'h0);

    // Randomized traffic with random back-pressure; requests held until accepted
    pend = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (!pend) begin
        pv  = ($urandom_range(0, 3) != 0);
        pwe = $urandom_range(0, 1) == 1;
        case ($urandom_range(0, 15))
          0:       pa = BASE + DEP + 32'($urandom_range(0, 64) * 4);
          1:       pa = BASE - 32'($urandom_range(1, 64) * 4);
          2:       pa = $urandom;
          default: pa = BASE + 32'($urandom_range(0, DEP/4 - 1) * 4) + 32'($urandom_range(0, 3));
        endcase
        pd = $urandom;
        pm = 4'($urandom_range(0, 15));
      end
      prr = ($urandom_range(0, 3) != 0);
      cycle(pv, pwe, pa, pd, pm, prr, acc);
      pend = pv && !acc;
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
